mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control sequencer for the RV32I core. It consumes the instruction-class flags, `rd` and the branch-compare result produced by the instruction decoder and ALU. From these it drives the write enables, mux selects and memory handshakes that step the shared datapath through fetch, decode, execute, memory and writeback, retiring one instruction at a time. It sits between the decoder/datapath and the instruction and data memory ports.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load`, `store`, `branch`, `jalr`, `jal`, `lui`, `auipc`, `op_imm`, `op`, `system` in 1 each: one-hot decoder class flags, sampled in DECODE/EXEC.
- `rd` in 5: destination register from the decoder.
- `br_taken` in 1: branch comparison result, valid in EXEC.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: fetch complete; instruction data valid this cycle.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a store.
- `dmem_ack` in 1: data access complete; load data valid this cycle.
- `ir_we` out 1: instruction-register load.
- `mdr_we` out 1: memory-data-register load.
- `pc_we` out 1: PC update; also marks the retire cycle.
- `pc_sel` out 2: next-PC source. 0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1.
- `rf_we` out 1: register-file write.
- `wb_sel` out 2: writeback source. 0 = ALU, 1 = MDR, 2 = pc+4, 3 = imm_u.
- `alu_a_sel` out 1: ALU A source. 0 = rs1, 1 = pc.
- `alu_b_sel` out 1: ALU B source. 0 = rs2, 1 = imm.
- `imm_sel` out 3: immediate format. 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `halted` out 1: core stopped on SYSTEM.
- `illegal` out 1: core stopped on unknown opcode.
- `cycle_cnt` out 64: cycle counter.
- `instret_cnt` out 64: retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, STOP. Reset state is IDLE.
- **IDLE**
  - All outputs are 0.
  - Goes to FETCH unconditionally on the next clock.
- **FETCH**
  - `imem_req`=1 until `imem_ack`.
  - On the ack cycle: `ir_we`=1, next state DECODE.
- **DECODE** (1 cycle)
  - No flag set: `illegal`←1, next STOP.
  - `system`: `halted`←1, next STOP.
  - Otherwise next EXEC.
- **EXEC**
  - `op`: `alu_b_sel`=0, `rf_we`, `pc_we`, `pc_sel`=0, `wb_sel`=0.
  - `op_imm`: same as `op` but `alu_b_sel`=1, `imm_sel`=I.
  - `lui`: `wb_sel`=3, `imm_sel`=U, `rf_we`, `pc_we`.
  - `auipc`: `alu_a_sel`=1, `alu_b_sel`=1, `imm_sel`=U, `wb_sel`=0, `rf_we`, `pc_we`.
  - `jal`: `imm_sel`=J, `wb_sel`=2, `pc_sel`=1, `rf_we`, `pc_we`.
  - `jalr`: `imm_sel`=I, `wb_sel`=2, `pc_sel`=2, `rf_we`, `pc_we`.
  - `branch`: `imm_sel`=B, `pc_we`, `pc_sel`=`br_taken`?1:0, no `rf_we`.
  - All classes above: next FETCH.
  - `load`/`store`: address computed with `alu_b_sel`=1, `imm_sel`=I (load) or S (store); next MEM.
- **MEM**
  - `dmem_req`=1 and `dmem_we`=`store`, held stable until `dmem_ack`.
  - On ack, store: `pc_we`, `pc_sel`=0, next FETCH.
  - On ack, load: `mdr_we`=1, next WB.
- **WB**: `rf_we`, `wb_sel`=1, `pc_we`, `pc_sel`=0, next FETCH.
- **STOP**
  - Absorbing; left only by reset.
  - `halted`/`illegal` stay registered high.
- `rf_we` is forced to 0 whenever `rd`==0.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.
- Selects not listed for a state are 0.
- All outputs are Moore/Mealy combinational from state and inputs, except `halted`, `illegal` and the counters, which are registered.

## Timing
- Asynchronous reset: state→IDLE, `halted`=`illegal`=0, counters=0, all outputs 0 during reset.
- First `imem_req` is asserted 1 cycle after `rst_n` rises.
- Zero-wait memory (ack in the request cycle):
  - ALU/jump/branch/lui/auipc: 3 cycles per instruction (FETCH, DECODE, EXEC).
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle before an ack adds exactly 1 cycle.
- Ack in the same cycle as the request is legal.
- Exactly one `pc_we` pulse per retired instruction. SYSTEM and illegal instructions do not retire.
- Reset asserted mid-MEM drops `dmem_req` immediately, with no completion. The memory side must tolerate an abandoned request.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - `cycle_cnt` increments every clock outside IDLE/STOP.
  - `instret_cnt` increments on every `pc_we`.
  - Both are 64-bit and wrap from 2^64−1 to 0.
- Undefined: both ports present but tied to 0, and no counter flops.

## Test plan
- ADDI retire: reset, zero-wait imem, `op_imm`=1, `rd`=5 → `ir_we` at cycle 1, `rf_we`=`pc_we`=1 with `alu_b_sel`=1 at cycle 3, `imem_req` again at cycle 4.
- Load with 2 wait states on both memories → `mdr_we` on the `dmem_ack` cycle, `rf_we`/`wb_sel`=1 next cycle, 9 cycles total. Same load with `rd`=0 → `rf_we`=0, `pc_we`=1.
- Branch → `br_taken`=1 gives `pc_sel`=1; `br_taken`=0 gives `pc_sel`=0; `rf_we`=0 in both cases.
- Flags all zero → `illegal`=1 after DECODE; no further `imem_req` for 20 cycles; `rst_n` low clears it.
- `system`=1 → `halted`=1, `illegal`=0; with `MC_CTRL_PERF_EN`, after 10 ADDIs then ECALL, `instret_cnt`=10 and `cycle_cnt` frozen.
- Reset pulse during a MEM wait → `dmem_req` falls asynchronously; after release, IDLE then FETCH; counters read 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core.
// Define MC_CTRL_PERF_EN to build the 64-bit cycle and retired-instruction counters.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        store,
  input  logic        branch,
  input  logic        jalr,
  input  logic        jal,
  input  logic        lui,
  input  logic        auipc,
  input  logic        op_imm,
  input  logic        op,
  input  logic        system,
  input  logic [4:0]  rd,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        halted,
  output logic        illegal,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MDR   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  localparam logic [1:0] WB_IMMU  = 2'd3;
  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_STOP
  } state_e;

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  logic   is_store_q, is_store_d;
  logic   any_flag;
  logic   rf_wr;

  assign any_flag = |{load, store, branch, jalr, jal, lui, auipc, op_imm, op, system};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      is_store_q <= is_store_d;
    end
  end

  // Next-state and datapath controls; the store/load choice is latched in EXEC so dmem_we stays stable in MEM.
  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    is_store_d = is_store_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    rf_wr      = 1'b0;
    wb_sel     = WB_ALU;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    imm_sel    = IMM_I;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!any_flag) begin
          illegal_d = 1'b1;
          state_d   = S_STOP;
        end else if (system) begin
          halted_d = 1'b1;
          state_d  = S_STOP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (op) begin
          wb_sel = WB_ALU;
          rf_wr  = 1'b1;
          pc_we  = 1'b1;
        end else if (op_imm) begin
          alu_b_sel = 1'b1;
          imm_sel   = IMM_I;
          rf_wr     = 1'b1;
          pc_we     = 1'b1;
        end else if (lui) begin
          wb_sel  = WB_IMMU;
          imm_sel = IMM_U;
          rf_wr   = 1'b1;
          pc_we   = 1'b1;
        end else if (auipc) begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
          imm_sel   = IMM_U;
          wb_sel    = WB_ALU;
          rf_wr     = 1'b1;
          pc_we     = 1'b1;
        end else if (jal) begin
          imm_sel = IMM_J;
          wb_sel  = WB_PC4;
          pc_sel  = PC_REL;
          rf_wr   = 1'b1;
          pc_we   = 1'b1;
        end else if (jalr) begin
          imm_sel = IMM_I;
          wb_sel  = WB_PC4;
          pc_sel  = PC_JALR;
          rf_wr   = 1'b1;
          pc_we   = 1'b1;
        end else if (branch) begin
          imm_sel = IMM_B;
          pc_sel  = br_taken ? PC_REL : PC_PLUS4;
          pc_we   = 1'b1;
        end else if (load || store) begin
          alu_b_sel  = 1'b1;
          imm_sel    = store ? IMM_S : IMM_I;
          is_store_d = store;
          state_d    = S_MEM;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store_q;
        if (dmem_ack) begin
          if (is_store_q) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_wr   = 1'b1;
        wb_sel  = WB_MDR;
        pc_we   = 1'b1;
        pc_sel  = PC_PLUS4;
        state_d = S_FETCH;
      end
      S_STOP: state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase
  end

  // x0 is hardwired, so no instruction may write it.
  assign rf_we   = rf_wr && (rd != 5'd0);
  assign halted  = halted_q;
  assign illegal = illegal_q;

`ifdef MC_CTRL_PERF_EN
  localparam int unsigned CNT_W = 64;

  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_IDLE && state_q != S_STOP) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (pc_we) instret_cnt_d = instret_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected output sequences are queued
// as stimulus is planned and popped/compared cycle by cycle as the DUT runs.
module tb_mc_ctrl;

  localparam int unsigned I_LOAD = 0, I_STORE = 1, I_BRANCH = 2, I_JALR = 3, I_JAL = 4;
  localparam int unsigned I_LUI = 5, I_AUIPC = 6, I_OPIMM = 7, I_OP = 8, I_SYS = 9;

`ifdef MC_CTRL_PERF_EN
  localparam logic [63:0] EXP_CYC = 64'd32;
  localparam logic [63:0] EXP_RET = 64'd10;
`else
  localparam logic [63:0] EXP_CYC = 64'd0;
  localparam logic [63:0] EXP_RET = 64'd0;
`endif

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] imm_sel;
    logic       halted;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    logic imem_ack;
    logic dmem_ack;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  flags;
  logic [4:0]  rd;
  logic        br_taken, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, mdr_we, pc_we, rf_we;
  logic        alu_a_sel, alu_b_sel, halted, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel;
  logic [63:0] cycle_cnt, instret_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load(flags[I_LOAD]), .store(flags[I_STORE]), .branch(flags[I_BRANCH]),
    .jalr(flags[I_JALR]), .jal(flags[I_JAL]), .lui(flags[I_LUI]), .auipc(flags[I_AUIPC]),
    .op_imm(flags[I_OPIMM]), .op(flags[I_OP]), .system(flags[I_SYS]),
    .rd(rd), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .imm_sel(imm_sel), .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  function automatic logic [9:0] fl(input int unsigned idx);
    return 10'(1) << idx;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.imem_req  = imem_req;   o.dmem_req  = dmem_req;  o.dmem_we = dmem_we;
    o.ir_we     = ir_we;      o.mdr_we    = mdr_we;    o.pc_we   = pc_we;
    o.pc_sel    = pc_sel;     o.rf_we     = rf_we;     o.wb_sel  = wb_sel;
    o.alu_a_sel = alu_a_sel;  o.alu_b_sel = alu_b_sel; o.imm_sel = imm_sel;
    o.halted    = halted;     o.illegal   = illegal;
    return o;
  endfunction

  // Plans one retiring instruction, then replays it against the DUT cycle by cycle.
  task automatic run_instr(input string nm, input logic [9:0] f, input logic [4:0] rdv,
                           input logic brt, input int iw, input int dw, input logic noise);
    exp_t  eq[$];
    stim_t sq[$];
    exp_t  e, o;
    stim_t s;
    logic  wr;
    int    cyc;
    wr = (rdv != 5'd0);
    for (int i = 0; i <= iw; i++) begin
      e = '0; e.imem_req = 1'b1; e.ir_we = (i == iw); eq.push_back(e);
      s.imem_ack = (i == iw); s.dmem_ack = noise; sq.push_back(s);
    end
    e = '0; eq.push_back(e);
    s.imem_ack = noise; s.dmem_ack = noise; sq.push_back(s);
    e = '0;
    if (f[I_OP]) begin
      e.rf_we = wr; e.pc_we = 1'b1;
    end else if (f[I_OPIMM]) begin
      e.alu_b_sel = 1'b1; e.imm_sel = 3'd0; e.rf_we = wr; e.pc_we = 1'b1;
    end else if (f[I_LUI]) begin
      e.wb_sel = 2'd3; e.imm_sel = 3'd3; e.rf_we = wr; e.pc_we = 1'b1;
    end else if (f[I_AUIPC]) begin
      e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1; e.imm_sel = 3'd3; e.rf_we = wr; e.pc_we = 1'b1;
    end else if (f[I_JAL]) begin
      e.imm_sel = 3'd4; e.wb_sel = 2'd2; e.pc_sel = 2'd1; e.rf_we = wr; e.pc_we = 1'b1;
    end else if (f[I_JALR]) begin
      e.imm_sel = 3'd0; e.wb_sel = 2'd2; e.pc_sel = 2'd2; e.rf_we = wr; e.pc_we = 1'b1;
    end else if (f[I_BRANCH]) begin
      e.imm_sel = 3'd2; e.pc_we = 1'b1; e.pc_sel = brt ? 2'd1 : 2'd0;
    end else begin
      e.alu_b_sel = 1'b1; e.imm_sel = f[I_STORE] ? 3'd1 : 3'd0;
    end
    eq.push_back(e); sq.push_back(s);
    if (f[I_LOAD] || f[I_STORE]) begin
      for (int j = 0; j <= dw; j++) begin
        e = '0; e.dmem_req = 1'b1; e.dmem_we = f[I_STORE];
        if (j == dw) begin
          e.pc_we  = f[I_STORE];
          e.mdr_we = f[I_LOAD];
        end
        eq.push_back(e);
        s.imem_ack = noise; s.dmem_ack = (j == dw); sq.push_back(s);
      end
      if (f[I_LOAD]) begin
        e = '0; e.rf_we = wr; e.wb_sel = 2'd1; e.pc_we = 1'b1; eq.push_back(e);
        s.imem_ack = noise; s.dmem_ack = noise; sq.push_back(s);
      end
    end
    flags = f; rd = rdv; br_taken = brt;
    cyc = 1;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      imem_ack = s.imem_ack; dmem_ack = s.dmem_ack;
      @(negedge clk);
      e = eq.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, o, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  // Fetch, decode and n cycles of the absorbing stop state for SYSTEM / unknown opcodes.
  task automatic run_stop(input string nm, input logic [9:0] f, input int n);
    exp_t eq[$];
    exp_t e, o;
    int   cyc;
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; eq.push_back(e);
    e = '0; eq.push_back(e);
    for (int i = 0; i < n; i++) begin
      e = '0; e.halted = f[I_SYS]; e.illegal = (f == 10'd0); eq.push_back(e);
    end
    flags = f; rd = 5'd1; br_taken = 1'b0;
    cyc = 1;
    while (eq.size() > 0) begin
      imem_ack = (cyc == 1);
      @(negedge clk);
      e = eq.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, o, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (observe() !== exp_t'(0)) begin
      bad++;
      $display("FAIL idle_after_reset: got %h want 0", observe());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (observe() !== exp_t'(0)) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", observe());
    end
    total++;
    if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
      bad++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
    end
    release_reset();
  endtask

  task automatic test_addi();
    run_instr("addi", fl(I_OPIMM), 5'd5, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_alu_classes();
    run_instr("op",    fl(I_OP),    5'd3,  1'b0, 0, 0, 1'b1);
    run_instr("lui",   fl(I_LUI),   5'd4,  1'b0, 1, 0, 1'b0);
    run_instr("auipc", fl(I_AUIPC), 5'd6,  1'b0, 0, 0, 1'b1);
    run_instr("jal",   fl(I_JAL),   5'd1,  1'b0, 2, 0, 1'b0);
    run_instr("jalr",  fl(I_JALR),  5'd31, 1'b0, 0, 0, 1'b1);
    run_instr("op_x0", fl(I_OP),    5'd0,  1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_load_wait();
    run_instr("load_w2",    fl(I_LOAD), 5'd7, 1'b0, 2, 2, 1'b0);
    run_instr("load_w2_x0", fl(I_LOAD), 5'd0, 1'b0, 2, 2, 1'b0);
    run_instr("load_w0",    fl(I_LOAD), 5'd9, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_store();
    run_instr("store_w0", fl(I_STORE), 5'd2, 1'b0, 0, 0, 1'b0);
    run_instr("store_w3", fl(I_STORE), 5'd2, 1'b0, 1, 3, 1'b1);
  endtask

  task automatic test_branch();
    run_instr("br_taken",     fl(I_BRANCH), 5'd8, 1'b1, 0, 0, 1'b0);
    run_instr("br_not_taken", fl(I_BRANCH), 5'd8, 1'b0, 1, 0, 1'b1);
  endtask

  task automatic test_mem_reset();
    flags = fl(I_LOAD); rd = 5'd3; br_taken = 1'b0;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL mem_wait_req: got %b want 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL async_drop_req: got %b want 0", dmem_req);
    end
    total++;
    if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
      bad++;
      $display("FAIL reset_clears_cnt: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
    end
    release_reset();
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || cycle_cnt !== 64'd0) begin
      bad++;
      $display("FAIL fetch_after_reset: got req=%b cyc=%0d want req=1 cyc=0", imem_req, cycle_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    run_stop("illegal", 10'd0, 20);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (illegal !== 1'b0) begin
      bad++;
      $display("FAIL illegal_cleared: got %b want 0", illegal);
    end
    release_reset();
  endtask

  task automatic test_system_perf();
    logic [63:0] snap;
    for (int k = 1; k <= 10; k++) run_instr("addi_seq", fl(I_OPIMM), 5'(k), 1'b0, 0, 0, 1'b0);
    run_stop("ecall", fl(I_SYS), 3);
    @(negedge clk);
    total++;
    if (halted !== 1'b1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL ecall_flags: got h=%b i=%b want h=1 i=0", halted, illegal);
    end
    total++;
    if (instret_cnt !== EXP_RET) begin
      bad++;
      $display("FAIL instret: got %0d want %0d", instret_cnt, EXP_RET);
    end
    total++;
    if (cycle_cnt !== EXP_CYC) begin
      bad++;
      $display("FAIL cycle_cnt: got %0d want %0d", cycle_cnt, EXP_CYC);
    end
    snap = EXP_CYC;
    repeat (5) @(negedge clk);
    total++;
    if (cycle_cnt !== snap || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL stop_frozen: got cyc=%0d req=%b want cyc=%0d req=0", cycle_cnt, imem_req, snap);
    end
  endtask

  initial begin
    rst_n = 1'b1; flags = '0; rd = '0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #2 rst_n = 1'b0;
    test_reset();
    test_addi();
    test_alu_classes();
    test_load_wait();
    test_store();
    test_branch();
    test_mem_reset();
    test_illegal();
    test_system_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
